// File: rtl/mem_stage_pipe_ctrl_if.sv
// Bundles the EX->MEM inputs, syncram write enable and MEM/WB outputs of the memory-stage slice.
// Latency: none (wiring only). Backpressure: none, since the pipeline advances every cycle.
// The slave modport is the stage itself. The master modport is the EX/WB side driving it.
interface mem_stage_pipe_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  addr;
    logic [1:0]         load_byte;
    logic               we;
    logic               memtoreg_ex;
    logic               regwrite_ex;
    logic [RADDR_W-1:0] towrite_ex;
    logic               branch_ex;
    logic               init_delay;

    logic               we_mem;
    logic [DATA_W-1:0]  dout_mem;
    logic [DATA_W-1:0]  dout;
    logic [DATA_W-1:0]  result_mem;
    logic               memtoreg_mem;
    logic               regwrite_mem;
    logic [RADDR_W-1:0] towrite_mem;
    logic               branch_stall_forwarding;

    modport slave (
        input  mem_rdata, addr, load_byte, we, memtoreg_ex, regwrite_ex,
               towrite_ex, branch_ex, init_delay,
        output we_mem, dout_mem, dout, result_mem, memtoreg_mem, regwrite_mem,
               towrite_mem, branch_stall_forwarding
    );

    modport master (
        output mem_rdata, addr, load_byte, we, memtoreg_ex, regwrite_ex,
               towrite_ex, branch_ex, init_delay,
        input  we_mem, dout_mem, dout, result_mem, memtoreg_mem, regwrite_mem,
               towrite_mem, branch_stall_forwarding
    );
endinterface

// File: rtl/mem_stage_pipe_ctrl.sv
// MEM stage: load-byte formatting, MEM/WB pipeline registers and the branch stall flag.
// Latency: dout_mem and we_mem are combinational; the MEM/WB outputs appear 1 cycle later.
// Backpressure: none. The stage updates every edge, and the stall flag does not block stores.
module mem_stage_pipe_ctrl #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int BR_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_stage_pipe_ctrl_if.slave  bus
);
    logic [DATA_W-1:0]   dout_mem_d;
    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   result_q;
    logic                memtoreg_q;
    logic                regwrite_q;
    logic [RADDR_W-1:0]  towrite_q;
    logic [BR_DEPTH-1:0] hist_q;
    logic [BR_DEPTH-1:0] hist_d;

    // The sign of a byte load is bit 7 of the raw word, whatever the upper bytes hold.
    always_comb begin
        dout_mem_d = bus.mem_rdata;
        case (bus.load_byte)
            2'b10:   dout_mem_d = {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]};
            2'b01:   dout_mem_d = {{(DATA_W-8){bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            default: dout_mem_d = bus.mem_rdata;
        endcase
    end

    generate
        if (BR_DEPTH == 1) begin : g_hist1
            assign hist_d = bus.branch_ex;
        end else begin : g_histn
            assign hist_d = {hist_q[BR_DEPTH-2:0], bus.branch_ex};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q     <= '0;
            result_q   <= '0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            towrite_q  <= '0;
            hist_q     <= '0;
        end else begin
            dout_q     <= dout_mem_d;
            result_q   <= bus.addr;
            memtoreg_q <= bus.memtoreg_ex;
            regwrite_q <= bus.regwrite_ex;
            towrite_q  <= bus.towrite_ex;
            hist_q     <= hist_d;
        end
    end

    assign bus.we_mem       = bus.we;
    assign bus.dout_mem     = dout_mem_d;
    assign bus.dout         = dout_q;
    assign bus.result_mem   = result_q;
    assign bus.memtoreg_mem = memtoreg_q;
    assign bus.regwrite_mem = regwrite_q;
    assign bus.towrite_mem  = towrite_q;
    // init_delay only masks the flag and leaves the history intact, so dropping it exposes the rest of the window.
    assign bus.branch_stall_forwarding = (|hist_q) & ~bus.init_delay;
endmodule

// File: tb/tb_mem_stage_pipe_ctrl.sv
// Randomized plus directed bench for mem_stage_pipe_ctrl, compared against a cycle-level reference model.
module tb_mem_stage_pipe_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int BD = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_pipe_ctrl_if #(.DATA_W(DW), .RADDR_W(RW)) bus ();

    mem_stage_pipe_ctrl #(.DATA_W(DW), .RADDR_W(RW), .BR_DEPTH(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus for the next cycle
    logic [31:0] s_rdata, s_addr;
    logic [1:0]  s_lb;
    logic        s_we, s_mtr, s_rw, s_br, s_init;
    logic [4:0]  s_tw;

    // Reference model: the expected MEM/WB contents and the edge index of the last sampled branch
    logic [31:0] m_dout, m_res;
    logic        m_mtr, m_rw;
    logic [4:0]  m_tw;
    int          edge_cnt = 0;
    int          last_br  = -1;
    int          flag_hi  = 0;

    function automatic logic [31:0] fmt(input logic [31:0] rdata, input logic [1:0] lb);
        logic [31:0] b;
        b = rdata & 32'h0000_00FF;
        if (lb == 2'd2) return b;
        if (lb == 2'd1) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        return rdata;
    endfunction

    function automatic logic stall_exp(input logic init);
        return (last_br >= 0) && ((edge_cnt - last_br) < BD) && !init;
    endfunction

    task automatic model_clear();
        m_dout = '0; m_res = '0; m_mtr = 1'b0; m_rw = 1'b0; m_tw = '0;
        last_br = -1;
    endtask

    task automatic rand_stim();
        s_rdata = $urandom; s_addr = $urandom; s_lb = 2'($urandom_range(0, 3));
        s_we = 1'($urandom); s_mtr = 1'($urandom); s_rw = 1'($urandom);
        s_tw = 5'($urandom); s_br = 1'b0; s_init = 1'b0;
    endtask

    task automatic drive();
        bus.mem_rdata   = s_rdata;  bus.addr        = s_addr;
        bus.load_byte   = s_lb;     bus.we          = s_we;
        bus.memtoreg_ex = s_mtr;    bus.regwrite_ex = s_rw;
        bus.towrite_ex  = s_tw;     bus.branch_ex   = s_br;
        bus.init_delay  = s_init;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "_dout"},     bus.dout,         m_dout);
        check({pfx, "_result"},   bus.result_mem,   m_res);
        check({pfx, "_memtoreg"}, bus.memtoreg_mem, m_mtr);
        check({pfx, "_regwrite"}, bus.regwrite_mem, m_rw);
        check({pfx, "_towrite"},  bus.towrite_mem,  m_tw);
    endtask

    // One cycle, entered just after a falling edge: combinational checks, then the edge, then registered checks.
    task automatic cycle();
        drive();
        #1;
        check("dout_mem", bus.dout_mem, fmt(s_rdata, s_lb));
        check("we_mem", bus.we_mem, s_we);
        check("flag_pre", bus.branch_stall_forwarding, stall_exp(s_init));
        @(posedge clk);
        edge_cnt++;
        m_dout = fmt(s_rdata, s_lb); m_res = s_addr;
        m_mtr = s_mtr; m_rw = s_rw; m_tw = s_tw;
        if (s_br) last_br = edge_cnt;
        #1;
        check_regs("post");
        check("flag_post", bus.branch_stall_forwarding, stall_exp(s_init));
        if (bus.branch_stall_forwarding) flag_hi++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rand_stim();
        s_br = 1'b1;
        drive();
        reset = 1'b1;
        model_clear();
        #1;
        check_regs("rst");
        check("rst_flag", bus.branch_stall_forwarding, 1'b0);
        @(posedge clk);
        #1;
        check_regs("rst_edge");
        check("rst_edge_flag", bus.branch_stall_forwarding, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rand_stim();
        drive();
        @(negedge clk);
        do_reset();

        // Load formatting, with literal expectations alongside the model
        rand_stim(); s_rdata = 32'h1234_5680; s_lb = 2'b10; cycle();
        check("lbu_comb", bus.dout_mem, 32'h0000_0080);
        check("lbu_reg",  bus.dout,     32'h0000_0080);
        s_lb = 2'b01; cycle();
        check("lb_comb", bus.dout_mem, 32'hFFFF_FF80);
        check("lb_reg",  bus.dout,     32'hFFFF_FF80);
        s_lb = 2'b00; cycle();
        check("lw_reg", bus.dout, 32'h1234_5680);
        s_rdata = 32'h0000_017F; s_lb = 2'b01; cycle();
        check("lb_pos_reg", bus.dout, 32'h0000_007F);

        // Pass-through for one cycle, then different values on the next
        rand_stim(); s_addr = 32'hDEAD_BEEF; s_tw = 5'd17; s_mtr = 1'b1; s_rw = 1'b1; cycle();
        check("pt_result", bus.result_mem, 32'hDEAD_BEEF);
        check("pt_towrite", bus.towrite_mem, 32'd17);
        rand_stim(); s_mtr = 1'b0; s_rw = 1'b0; cycle();
        check("pt_next_mtr", bus.memtoreg_mem, 1'b0);

        // A single pulse holds the flag for 3 cycles
        flag_hi = 0;
        rand_stim(); s_br = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin rand_stim(); cycle(); end
        check("pulse_len", flag_hi, 3);

        // Two pulses 2 cycles apart keep the flag high for 5 cycles
        flag_hi = 0;
        rand_stim(); s_br = 1'b1; cycle();
        rand_stim(); cycle();
        rand_stim(); s_br = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin rand_stim(); cycle(); end
        check("double_len", flag_hi, 5);

        // init_delay masks the flag, then the remaining history shows through
        flag_hi = 0;
        rand_stim(); s_br = 1'b1; s_init = 1'b1; cycle();
        check("init_mask", bus.branch_stall_forwarding, 1'b0);
        for (int i = 0; i < 4; i++) begin rand_stim(); cycle(); end
        check("init_remain", flag_hi, 2);

        // Asynchronous reset between edges while the flag is high
        rand_stim(); s_br = 1'b1; cycle();
        @(posedge clk);
        #2;
        check("pre_arst_flag", bus.branch_stall_forwarding, 1'b1);
        reset = 1'b1;
        model_clear();
        #1;
        check("arst_flag", bus.branch_stall_forwarding, 1'b0);
        check_regs("arst");
        @(negedge clk);
        reset = 1'b0;
        rand_stim(); cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            rand_stim();
            s_br   = ($urandom_range(0, 3) == 0);
            s_init = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
